// File: rtl/trace_check_pkg.sv
// rtl/trace_check_pkg.sv - shared encodings and event record layout for the lockstep trace checker
package trace_check_pkg;

  localparam logic [1:0] KIND_IFETCH = 2'd0;
  localparam logic [1:0] KIND_LOAD   = 2'd1;
  localparam logic [1:0] KIND_STORE  = 2'd2;

  localparam logic [3:0] ERR_NONE     = 4'd0;
  localparam logic [3:0] ERR_KIND     = 4'd1;
  localparam logic [3:0] ERR_ADDR     = 4'd2;
  localparam logic [3:0] ERR_STRB     = 4'd3;
  localparam logic [3:0] ERR_WDATA    = 4'd4;
  localparam logic [3:0] ERR_OVF      = 4'd5;
  localparam logic [3:0] ERR_SKEW     = 4'd6;
  localparam logic [3:0] ERR_PC       = 4'd7;
  localparam logic [3:0] ERR_LOCKSTEP = 4'd8;

  // Record layout, LSB first; the top 32 bits are reserved and always zero.
  localparam int EV_W         = 134;
  localparam int EV_WDATA_LSB = 0;
  localparam int EV_WSTRB_LSB = 32;
  localparam int EV_ADDR_LSB  = 36;
  localparam int EV_PC_LSB    = 68;
  localparam int EV_KIND_LSB  = 100;
  localparam int EV_RSV_LSB   = 102;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_FINISH_WAIT = 2'd1,
    ST_PASS        = 2'd2,
    ST_FAIL        = 2'd3
  } state_e;

  function automatic logic [EV_W-1:0] pack_event(
    input logic [1:0]  kind,
    input logic [31:0] pc,
    input logic [31:0] addr,
    input logic [3:0]  wstrb,
    input logic [31:0] wdata
  );
    return {32'h0, kind, pc, addr, wstrb, wdata};
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO holding one CPU's memory-event records
module trace_fifo
  import trace_check_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = EV_W
) (
  input  logic         sys_clk,
  input  logic         sys_reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/lockstep_trace_checker.sv
// rtl/lockstep_trace_checker.sv - in-order DUT/golden memory-event comparator with bounded skew
module lockstep_trace_checker
  import trace_check_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter int          MAX_SKEW    = 1024,
  parameter bit          LOCKSTEP    = 1'b0,
  parameter logic [31:0] FINISH_ADDR = 32'h0000000C,
  parameter int          CNT_W       = 32
) (
  input  logic             sys_clk,
  input  logic             sys_reset_n,
  input  logic             check_en,
  input  logic             dut_valid,
  input  logic [1:0]       dut_kind,
  input  logic [31:0]      dut_pc,
  input  logic [31:0]      dut_addr,
  input  logic [3:0]       dut_wstrb,
  input  logic [31:0]      dut_wdata,
  input  logic             gold_valid,
  input  logic [1:0]       gold_kind,
  input  logic [31:0]      gold_pc,
  input  logic [31:0]      gold_addr,
  input  logic [3:0]       gold_wstrb,
  input  logic [31:0]      gold_wdata,
  input  logic             uart_fifo_empty,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [3:0]       err_code,
  output logic [31:0]      err_pc,
  output logic [31:0]      err_dut_word,
  output logic [31:0]      err_gold_word,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int SKEW_W = $clog2(MAX_SKEW + 1);

  state_e            state, state_next;
  logic              active, pop;
  logic              dut_full, dut_empty, gold_full, gold_empty;
  logic              dut_ovf, gold_ovf, dut_push, gold_push;
  logic [EV_W-1:0]   dut_head, gold_head;
  logic [SKEW_W-1:0] skew_cnt;
  logic              one_sided, skew_err, lock_err, finish_hit;

  logic [1:0]  d_kind, g_kind;
  logic [31:0] d_pc, g_pc, d_addr, g_addr, d_wdata, g_wdata, g_mask;
  logic [3:0]  d_wstrb, g_wstrb;

  logic [3:0]  cmp_code, sel_code;
  logic [31:0] cmp_dw, cmp_gw, sel_pc, sel_dw, sel_gw;
  logic        unused_rsv;

  // Both streams stop being accepted once the verdict is terminal.
  assign active    = check_en && (state == ST_RUN || state == ST_FINISH_WAIT);
  assign pop       = active && !dut_empty && !gold_empty;
  assign dut_ovf   = active && dut_valid && dut_full && !pop;
  assign gold_ovf  = active && gold_valid && gold_full && !pop;
  assign dut_push  = active && dut_valid && !dut_ovf;
  assign gold_push = active && gold_valid && !gold_ovf;

  trace_fifo #(.DEPTH(DEPTH), .W(EV_W)) u_dut_fifo (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .push        (dut_push),
    .push_data   (pack_event(dut_kind, dut_pc, dut_addr, dut_wstrb, dut_wdata)),
    .pop         (pop),
    .head        (dut_head),
    .full        (dut_full),
    .empty       (dut_empty)
  );

  trace_fifo #(.DEPTH(DEPTH), .W(EV_W)) u_gold_fifo (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .push        (gold_push),
    .push_data   (pack_event(gold_kind, gold_pc, gold_addr, gold_wstrb, gold_wdata)),
    .pop         (pop),
    .head        (gold_head),
    .full        (gold_full),
    .empty       (gold_empty)
  );

  assign d_kind  = dut_head[EV_KIND_LSB +: 2];
  assign g_kind  = gold_head[EV_KIND_LSB +: 2];
  assign d_pc    = dut_head[EV_PC_LSB +: 32];
  assign g_pc    = gold_head[EV_PC_LSB +: 32];
  assign d_addr  = dut_head[EV_ADDR_LSB +: 32];
  assign g_addr  = gold_head[EV_ADDR_LSB +: 32];
  assign d_wstrb = dut_head[EV_WSTRB_LSB +: 4];
  assign g_wstrb = gold_head[EV_WSTRB_LSB +: 4];
  assign d_wdata = dut_head[EV_WDATA_LSB +: 32];
  assign g_wdata = gold_head[EV_WDATA_LSB +: 32];
  assign g_mask  = strb_mask(g_wstrb);

  assign unused_rsv = ^{dut_head[EV_W-1:EV_RSV_LSB], gold_head[EV_W-1:EV_RSV_LSB]};

  always_comb begin
    cmp_code = ERR_NONE;
    cmp_dw   = '0;
    cmp_gw   = '0;
    if (d_kind != g_kind) begin
      cmp_code = ERR_KIND;
      cmp_dw   = {30'd0, d_kind};
      cmp_gw   = {30'd0, g_kind};
    end else if (g_kind == KIND_IFETCH && d_pc != g_pc) begin
      cmp_code = ERR_PC;
      cmp_dw   = d_pc;
      cmp_gw   = g_pc;
    end else if (d_addr[31:2] != g_addr[31:2]) begin
      cmp_code = ERR_ADDR;
      cmp_dw   = d_addr;
      cmp_gw   = g_addr;
    end else if (g_kind == KIND_STORE && d_wstrb != g_wstrb) begin
      cmp_code = ERR_STRB;
      cmp_dw   = {28'd0, d_wstrb};
      cmp_gw   = {28'd0, g_wstrb};
    end else if (g_kind == KIND_STORE && (d_wdata & g_mask) != (g_wdata & g_mask)) begin
      cmp_code = ERR_WDATA;
      cmp_dw   = d_wdata;
      cmp_gw   = g_wdata;
    end
  end

  assign one_sided  = (dut_empty != gold_empty);
  assign skew_err   = active && one_sided && (skew_cnt == SKEW_W'(MAX_SKEW - 1));
  assign lock_err   = LOCKSTEP && active && (dut_valid != gold_valid);
  assign finish_hit = pop && cmp_code == ERR_NONE && g_kind == KIND_STORE &&
                      g_addr == FINISH_ADDR && (g_wdata & g_mask) == 32'd0;

  // Sources are applied highest code first so the lowest code of the cycle wins.
  always_comb begin
    sel_code = ERR_NONE;
    sel_pc   = '0;
    sel_dw   = '0;
    sel_gw   = '0;
    if (lock_err) begin
      sel_code = ERR_LOCKSTEP;
      sel_pc   = dut_pc;
    end
    if (pop && cmp_code == ERR_PC) begin
      sel_code = cmp_code;
      sel_pc   = d_pc;
      sel_dw   = cmp_dw;
      sel_gw   = cmp_gw;
    end
    if (skew_err) begin
      sel_code = ERR_SKEW;
      sel_pc   = dut_empty ? 32'd0 : d_pc;
      sel_dw   = '0;
      sel_gw   = '0;
    end
    if (dut_ovf || gold_ovf) begin
      sel_code = ERR_OVF;
      sel_pc   = dut_pc;
      sel_dw   = '0;
      sel_gw   = '0;
    end
    if (pop && cmp_code != ERR_NONE && cmp_code != ERR_PC) begin
      sel_code = cmp_code;
      sel_pc   = d_pc;
      sel_dw   = cmp_dw;
      sel_gw   = cmp_gw;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (active) begin
          if (sel_code != ERR_NONE) state_next = ST_FAIL;
          else if (finish_hit)      state_next = ST_FINISH_WAIT;
        end
      end
      ST_FINISH_WAIT: begin
        if (active) begin
          if (sel_code != ERR_NONE)  state_next = ST_FAIL;
          else if (uart_fifo_empty)  state_next = ST_PASS;
        end
      end
      default: state_next = state;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) state <= ST_RUN;
    else              state <= state_next;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      skew_cnt      <= '0;
      match_cnt     <= '0;
      err_code      <= ERR_NONE;
      err_pc        <= '0;
      err_dut_word  <= '0;
      err_gold_word <= '0;
    end else begin
      if (active) skew_cnt <= one_sided ? skew_cnt + SKEW_W'(1) : '0;
      if (pop && cmp_code == ERR_NONE && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
      if (state_next == ST_FAIL && state != ST_FAIL) begin
        err_code      <= sel_code;
        err_pc        <= sel_pc;
        err_dut_word  <= sel_dw;
        err_gold_word <= sel_gw;
      end
    end
  end

  assign done = (state == ST_PASS) || (state == ST_FAIL);
  assign pass = (state == ST_PASS);
  assign fail = (state == ST_FAIL);

endmodule

// File: doc/lockstep_trace_checker.md
Name: lockstep_trace_checker

Overview:
- Synthesizable successor to the simulation-only lockstep DUT/golden comparator used for custom_cpu benches.
- Accepts two memory-interface event streams, one from the DUT CPU and one from the golden CPU, and buffers each in its own FIFO.
- Compares events in order and tolerates bounded timing skew between the two CPUs; a strict cycle-lockstep mode is kept.
- Reports pass/fail, the first mismatch, and benchmark completion.
- Sits beside both CPUs in cpu_test_top, for FPGA-resident checking.

Parameters:
DEPTH, 16, per-stream FIFO entries (power of two, >=2)
MAX_SKEW, 1024, cycles one FIFO may stay non-empty while the other is empty before a skew failure
LOCKSTEP, 0, 1 = dut_valid and gold_valid must be equal every cycle
FINISH_ADDR, 32'h0000000C, address of the benchmark-finish store
CNT_W, 32, width of the matched-event counter

Ports:
sys_clk  in  1  clock
sys_reset_n  in  1  synchronous active-low reset
check_en  in  1  enable; while 0, inputs are ignored and the FSM holds
dut_valid  in  1  DUT event strobe, one event per cycle
dut_kind  in  2  0 IFETCH, 1 LOAD, 2 STORE
dut_pc  in  32  PC associated with the event
dut_addr  in  32  fetch/load/store address
dut_wstrb  in  4  store byte strobes
dut_wdata  in  32  store data
gold_valid, gold_kind, gold_pc, gold_addr, gold_wstrb, gold_wdata  in  same widths  golden stream
uart_fifo_empty  in  1  UART simulation FIFO drained
done  out  1  PASS or FAIL reached
pass  out  1  benchmark passed
fail  out  1  mismatch detected
err_code  out  4  first error cause
err_pc  out  32  DUT PC of the failing event
err_dut_word  out  32  DUT field value that mismatched
err_gold_word  out  32  golden field value that mismatched
match_cnt  out  CNT_W  number of events compared equal

Behaviour:
- Reset (sys_reset_n=0 at a sys_clk edge): FIFOs emptied, FSM to RUN, skew counter cleared; done, pass, fail, err_* and match_cnt all 0.
- FIFO push: when valid && check_en, the 134-bit event is pushed. Push and pop in the same cycle on a full FIFO is legal (pop frees the slot).
- Overflow: push to a full FIFO with no pop that cycle -> FAIL, err_code 5.
- Compare: in RUN, when both FIFO heads are valid, both are popped in the same cycle.
- Compare priority, first hit wins:
  - kind differs -> code 1
  - IFETCH with pc differing -> code 7
  - addr[31:2] differs -> code 2
  - STORE with wstrb differing -> code 3
  - STORE with (wdata & mask) differing -> code 4, where mask is gold_wstrb expanded bytewise.
- err_dut_word / err_gold_word capture the offending field; kind is zero-extended to 32 bits.
- Match: match_cnt increments, saturating at all-ones.
- Latency: the compare result is registered, so fail and err_* assert 1 cycle after the pop.
- Skew: the counter increments each cycle exactly one FIFO is non-empty and resets otherwise. Reaching MAX_SKEW -> FAIL, code 6.
- Lockstep (LOCKSTEP=1): dut_valid != gold_valid in any check_en cycle -> FAIL, code 8, checked before the compare.
- FSM states:
  - RUN: a matched STORE with addr==FINISH_ADDR and masked wdata==0 -> FINISH_WAIT.
  - FINISH_WAIT: comparison continues; uart_fifo_empty=1 -> PASS. A mismatch -> FAIL.
  - PASS and FAIL are terminal until reset. done=1 in both; pass or fail=1 respectively. Pushes are ignored.
- Simultaneous errors: the lowest-numbered condition of the cycle is recorded; err_* freeze at the first failure.
- check_en=0: no push, no pop, skew counter holds.
- Reset asserted mid-run discards all buffered events.

Decomposition:
- Package trace_check_pkg holds:
  - kind encodings KIND_IFETCH/LOAD/STORE
  - error codes ERR_KIND=1, ERR_ADDR=2, ERR_STRB=3, ERR_WDATA=4, ERR_OVF=5, ERR_SKEW=6, ERR_PC=7, ERR_LOCKSTEP=8
  - event record width EV_W=134 and field offsets
  - FSM state encodings.
- One sub-module, trace_fifo: synchronous FIFO, parameter DEPTH, data width EV_W, with push/pop/full/empty. It is instantiated twice.

Test Plan:
1. Identical streams of 40 IFETCH/LOAD/STORE events, golden delayed 7 cycles, ending with STORE addr 0x0C data 0, uart_fifo_empty high 5 cycles later -> pass=1, done=1, match_cnt=40, fail=0.
2. STORE addr 0x100, wstrb 4'b0011: DUT wdata 0xDEAD1234, gold 0xBEEF1234 -> match. Same with gold 0xBEEF1235 -> fail, err_code 4, err_dut_word 0xDEAD1234.
3. IFETCH with DUT pc 0x1004 vs gold pc 0x1008 -> fail one cycle after the pop, err_code 7, err_pc 0x1004.
4. MAX_SKEW=8, DUT pushes 1 event, gold silent -> fail on the 8th cycle, err_code 6.
5. DEPTH=4, DUT pushes 5 events with gold silent -> fail on the 5th push, err_code 5. Repeat with a pop in the same cycle as a full push -> no failure.
6. LOCKSTEP=1, dut_valid=1 with gold_valid=0 in one cycle -> err_code 8. Then reset low for one edge -> all outputs 0 and FSM in RUN.
